// File: rtl/fast_frame_sequencer.sv
// Frame sequencer for the FAST detector: streams one frame from a fixed-latency pixel
// memory, pads the detector pipeline with zeros, and buffers flagged keypoints in a FWFT FIFO.
`timescale 1ns/1ps
module fast_frame_sequencer #(
    parameter int WIDTH      = 640,
    parameter int HEIGHT     = 480,
    parameter int FIFO_DEPTH = 16,
    parameter int ADDR_W     = 19
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_frame_req,
    output logic              o_busy,
    output logic              o_frame_done,
    output logic              o_mem_rd,
    output logic [ADDR_W-1:0] o_mem_addr,
    input  logic [7:0]        i_mem_data,
    input  logic              i_det_ready,
    output logic              o_det_start,
    output logic [7:0]        o_det_pixel,
    input  logic              i_det_flag,
    input  logic [9:0]        i_det_x,
    input  logic [9:0]        i_det_y,
    input  logic [7:0]        i_det_score,
    input  logic              i_det_end,
    output logic              o_kp_valid,
    input  logic              i_kp_ready,
    output logic [9:0]        o_kp_x,
    output logic [9:0]        o_kp_y,
    output logic [7:0]        o_kp_score,
    output logic [15:0]       o_kp_count,
    output logic              o_overflow,
    output logic [2:0]        o_dbg_state
);
    // One extra address bit so the read counter can reach WIDTH*HEIGHT itself.
    localparam int            CW       = ADDR_W + 1;
    localparam logic [CW-1:0] NPIX     = CW'(WIDTH * HEIGHT);
    localparam int            PW       = $clog2(FIFO_DEPTH);
    localparam logic [PW:0]   FULL_CNT = (PW + 1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_STREAM, S_FLUSH, S_DRAIN, S_DONE
    } state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  addr_q, addr_d;
    logic [15:0]    kp_count_q, kp_count_d;
    logic           overflow_q, overflow_d;
    logic [PW-1:0]  wptr_q, rptr_q;
    logic [PW:0]    fill_q;
    logic [27:0]    fifo_mem [FIFO_DEPTH];
    logic [27:0]    head;
    logic           empty, full, capture, push, pop;

    // Keypoint output handshake: an entry transfers on any cycle where o_kp_valid and
    // i_kp_ready are both high; head fields are stable while o_kp_valid waits for ready.
    assign empty   = (fill_q == '0);
    assign full    = (fill_q == FULL_CNT);
    assign pop     = !empty && i_kp_ready;
    assign capture = i_det_flag &&
                     (state_q == S_STREAM || state_q == S_FLUSH || state_q == S_DRAIN);
    assign push    = capture && (!full || pop);

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        kp_count_d   = kp_count_q;
        overflow_d   = overflow_q;
        o_busy       = 1'b1;
        o_frame_done = 1'b0;
        o_mem_rd     = 1'b0;
        o_mem_addr   = '0;
        o_det_start  = 1'b0;
        o_det_pixel  = '0;
        case (state_q)
            S_IDLE: begin
                o_busy = 1'b0;
                if (i_frame_req && i_det_ready) begin
                    o_mem_rd   = 1'b1;
                    addr_d     = CW'(1);
                    kp_count_d = '0;
                    overflow_d = 1'b0;
                    state_d    = S_LOAD;
                end
            end
            S_LOAD: begin
                o_det_start = 1'b1;
                o_det_pixel = i_mem_data;
                o_mem_rd    = 1'b1;
                o_mem_addr  = addr_q[ADDR_W-1:0];
                addr_d      = addr_q + CW'(1);
                state_d     = S_STREAM;
            end
            S_STREAM: begin
                o_det_pixel = i_mem_data;
                if (addr_q < NPIX) begin
                    o_mem_rd   = 1'b1;
                    o_mem_addr = addr_q[ADDR_W-1:0];
                    addr_d     = addr_q + CW'(1);
                end else begin
                    // This cycle carries the last pixel; no read left outstanding.
                    state_d = S_FLUSH;
                end
            end
            S_FLUSH: begin
                if (i_det_end) state_d = S_DRAIN;
            end
            S_DRAIN: state_d = S_DONE;
            S_DONE: begin
                if (empty) begin
                    o_frame_done = 1'b1;
                    o_busy       = 1'b0;
                    state_d      = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (capture) begin
            if (push) begin
                if (kp_count_q != 16'hFFFF) kp_count_d = kp_count_q + 16'd1;
            end else begin
                overflow_d = 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            kp_count_q <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            kp_count_q <= kp_count_d;
            overflow_q <= overflow_d;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
            fill_q <= '0;
        end else begin
            if (push) wptr_q <= wptr_q + 1'b1;
            if (pop)  rptr_q <= rptr_q + 1'b1;
            case ({push, pop})
                2'b10:   fill_q <= fill_q + 1'b1;
                2'b01:   fill_q <= fill_q - 1'b1;
                default: fill_q <= fill_q;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (push) fifo_mem[wptr_q] <= {i_det_x, i_det_y, i_det_score};
    end

    // Head fields are forced to zero when empty so reset leaves every output at 0.
    assign head        = empty ? 28'd0 : fifo_mem[rptr_q];
    assign o_kp_valid  = !empty;
    assign o_kp_x      = head[27:18];
    assign o_kp_y      = head[17:8];
    assign o_kp_score  = head[7:0];
    assign o_kp_count  = kp_count_q;
    assign o_overflow  = overflow_q;
    assign o_dbg_state = state_q;

endmodule

// File: tb/tb_fast_frame_sequencer.sv
// Self-checking bench for fast_frame_sequencer on an 8x6 frame with a 4-entry keypoint FIFO.
`timescale 1ns/1ps
module tb_fast_frame_sequencer;
    localparam int WIDTH      = 8;
    localparam int HEIGHT     = 6;
    localparam int FIFO_DEPTH = 4;
    localparam int ADDR_W     = 6;
    localparam int NPIX       = WIDTH * HEIGHT;
    localparam int FLUSH_LEN  = 4 * WIDTH + 15;
    localparam int T_END      = NPIX + FLUSH_LEN;   // offset of i_det_end from acceptance
    localparam int MAXC       = 400;

    logic              clk;
    logic              i_rst_n;
    logic              i_frame_req;
    logic              o_busy, o_frame_done, o_mem_rd;
    logic [ADDR_W-1:0] o_mem_addr;
    logic [7:0]        i_mem_data;
    logic              i_det_ready;
    logic              o_det_start;
    logic [7:0]        o_det_pixel;
    logic              i_det_flag;
    logic [9:0]        i_det_x, i_det_y;
    logic [7:0]        i_det_score;
    logic              i_det_end;
    logic              o_kp_valid;
    logic              i_kp_ready;
    logic [9:0]        o_kp_x, o_kp_y;
    logic [7:0]        o_kp_score;
    logic [15:0]       o_kp_count;
    logic              o_overflow;
    logic [2:0]        o_dbg_state;

    fast_frame_sequencer #(
        .WIDTH(WIDTH), .HEIGHT(HEIGHT), .FIFO_DEPTH(FIFO_DEPTH), .ADDR_W(ADDR_W)
    ) dut (
        .i_clk(clk), .i_rst_n(i_rst_n), .i_frame_req(i_frame_req),
        .o_busy(o_busy), .o_frame_done(o_frame_done),
        .o_mem_rd(o_mem_rd), .o_mem_addr(o_mem_addr), .i_mem_data(i_mem_data),
        .i_det_ready(i_det_ready), .o_det_start(o_det_start), .o_det_pixel(o_det_pixel),
        .i_det_flag(i_det_flag), .i_det_x(i_det_x), .i_det_y(i_det_y),
        .i_det_score(i_det_score), .i_det_end(i_det_end),
        .o_kp_valid(o_kp_valid), .i_kp_ready(i_kp_ready),
        .o_kp_x(o_kp_x), .o_kp_y(o_kp_y), .o_kp_score(o_kp_score),
        .o_kp_count(o_kp_count), .o_overflow(o_overflow), .o_dbg_state(o_dbg_state)
    );

    // Clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Pixel memory: data for a read issued in one cycle appears for the whole next cycle;
    // unread cycles carry junk so any leak into the pixel stream shows up.
    logic [7:0]        mem_img [NPIX];
    logic              mem_rd_s   = 1'b0;
    logic [ADDR_W-1:0] mem_addr_s = '0;
    always @(negedge clk) begin
        #1;
        mem_rd_s   = o_mem_rd;
        mem_addr_s = o_mem_addr;
    end
    always @(posedge clk) begin
        if (mem_rd_s && int'(mem_addr_s) < NPIX) i_mem_data <= mem_img[mem_addr_s];
        else                                     i_mem_data <= 8'($urandom);
    end

    // Stimulus tables indexed by cycle offset from request acceptance
    logic        flag_tab  [MAXC];
    logic        ready_tab [MAXC];
    logic        req_tab   [MAXC];
    logic [27:0] pay_tab   [MAXC];

    // Scoreboard / reference model
    logic [27:0] exp_q[$];
    int          m_count;
    bit          m_ovf;
    int          done_t;
    int          errors;
    int          checks;

    task automatic clear_tabs();
        for (int i = 0; i < MAXC; i++) begin
            flag_tab[i]  = 1'b0;
            ready_tab[i] = 1'b1;
            req_tab[i]   = 1'b0;
            pay_tab[i]   = 28'($urandom);
        end
        for (int i = 0; i < NPIX; i++) mem_img[i] = 8'($urandom);
    endtask

    // Drives one frame from acceptance at offset 0; returns early at offset stop_at.
    task automatic run_frame(input int stop_at, input string tag);
        bit          done_seen;
        bit          exp_rd, exp_done, exp_busy, pop, cap;
        logic [7:0]  exp_pix;
        logic [27:0] hd;
        done_seen = 0;
        done_t    = -1;
        for (int t = 0; t < MAXC && !done_seen; t++) begin
            @(negedge clk);
            if (t == stop_at) return;
            i_frame_req = (t == 0) ? 1'b1 : req_tab[t];
            i_det_ready = (t == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            i_det_flag  = flag_tab[t];
            {i_det_x, i_det_y, i_det_score} = pay_tab[t];
            i_kp_ready  = ready_tab[t];
            i_det_end   = (t == T_END);
            #1;
            exp_rd   = (t <= NPIX - 1);
            exp_pix  = (t >= 1 && t <= NPIX) ? mem_img[t-1] : 8'd0;
            exp_done = (t >= T_END + 2) && (exp_q.size() == 0);
            exp_busy = (t >= 1) && !exp_done;
            checks++;
            if (o_mem_rd !== exp_rd) begin
                errors++; $display("FAIL %s t=%0d mem_rd: got %b want %b", tag, t, o_mem_rd, exp_rd);
            end
            if (exp_rd) begin
                checks++;
                if (o_mem_addr !== ADDR_W'(t)) begin
                    errors++; $display("FAIL %s t=%0d mem_addr: got %0d want %0d", tag, t, o_mem_addr, t);
                end
            end
            checks++;
            if (o_det_start !== (t == 1)) begin
                errors++; $display("FAIL %s t=%0d det_start: got %b want %b", tag, t, o_det_start, (t == 1));
            end
            if (t >= 1 && t <= T_END) begin
                checks++;
                if (o_det_pixel !== exp_pix) begin
                    errors++; $display("FAIL %s t=%0d det_pixel: got %0d want %0d", tag, t, o_det_pixel, exp_pix);
                end
            end
            checks++;
            if (o_busy !== exp_busy || o_frame_done !== exp_done) begin
                errors++;
                $display("FAIL %s t=%0d busy/done: got %b/%b want %b/%b", tag, t, o_busy, o_frame_done, exp_busy, exp_done);
            end
            checks++;
            if (o_kp_valid !== (exp_q.size() > 0)) begin
                errors++; $display("FAIL %s t=%0d kp_valid: got %b want %b", tag, t, o_kp_valid, (exp_q.size() > 0));
            end else if (exp_q.size() > 0) begin
                hd = exp_q[0];
                checks++;
                if ({o_kp_x, o_kp_y, o_kp_score} !== hd) begin
                    errors++;
                    $display("FAIL %s t=%0d kp_head: got %0d,%0d,%0d want %0d,%0d,%0d", tag, t,
                             o_kp_x, o_kp_y, o_kp_score, hd[27:18], hd[17:8], hd[7:0]);
                end
            end
            checks++;
            if (o_kp_count !== 16'(m_count) || o_overflow !== m_ovf) begin
                errors++;
                $display("FAIL %s t=%0d count/ovf: got %0d/%b want %0d/%b", tag, t, o_kp_count, o_overflow, m_count, m_ovf);
            end
            // Model update for the edge ending this cycle
            if (t == 0) begin
                m_count = 0;
                m_ovf   = 0;
            end
            pop = (exp_q.size() > 0) && ready_tab[t];
            cap = flag_tab[t] && (t >= 2) && (t <= T_END + 1);
            if (pop) void'(exp_q.pop_front());
            if (cap) begin
                if (exp_q.size() < FIFO_DEPTH) begin
                    exp_q.push_back(pay_tab[t]);
                    if (m_count < 65535) m_count++;
                end else begin
                    m_ovf = 1;
                end
            end
            if (exp_done) begin
                done_seen = 1;
                done_t    = t;
            end
        end
        checks++;
        if (!done_seen) begin
            errors++; $display("FAIL %s frame_done_timeout: got none want pulse within %0d cycles", tag, MAXC);
        end
        @(negedge clk);
        i_frame_req = 1'b0;
        i_det_flag  = 1'b0;
        i_det_end   = 1'b0;
        i_kp_ready  = 1'b1;
        #1;
        checks++;
        if (o_busy !== 1'b0 || o_frame_done !== 1'b0 || o_kp_valid !== 1'b0 ||
            o_kp_count !== 16'(m_count) || o_overflow !== m_ovf) begin
            errors++;
            $display("FAIL %s post_done: got busy=%b done=%b valid=%b cnt=%0d ovf=%b want 0/0/0/%0d/%b",
                     tag, o_busy, o_frame_done, o_kp_valid, o_kp_count, o_overflow, m_count, m_ovf);
        end
    endtask

    task automatic test_reset();
        i_rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if ({o_busy, o_frame_done, o_mem_rd, o_mem_addr, o_det_start, o_det_pixel, o_kp_valid,
             o_kp_x, o_kp_y, o_kp_score, o_kp_count, o_overflow} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got busy=%b rd=%b addr=%0d pix=%0d valid=%b cnt=%0d ovf=%b want all 0",
                     o_busy, o_mem_rd, o_mem_addr, o_det_pixel, o_kp_valid, o_kp_count, o_overflow);
        end
        @(negedge clk);
        i_rst_n = 1'b1;
        exp_q.delete();
        m_count = 0;
        m_ovf   = 0;
    endtask

    task automatic test_single_frame();
        clear_tabs();
        run_frame(-1, "single");
        checks++;
        if (done_t !== T_END + 2) begin
            errors++; $display("FAIL single done_delay: got t=%0d want t=%0d", done_t, T_END + 2);
        end
    endtask

    task automatic test_two_keypoints();
        clear_tabs();
        flag_tab[1] = 1'b1;                          // LOAD: ignored
        flag_tab[40] = 1'b1; pay_tab[40] = {10'd3, 10'd2, 8'd40};
        flag_tab[60] = 1'b1; pay_tab[60] = {10'd5, 10'd4, 8'd25};
        flag_tab[T_END + 2] = 1'b1;                  // DONE: ignored
        run_frame(-1, "two_kp");
        checks++;
        if (o_kp_count !== 16'd2 || o_overflow !== 1'b0) begin
            errors++; $display("FAIL two_kp final: got cnt=%0d ovf=%b want 2/0", o_kp_count, o_overflow);
        end
    endtask

    task automatic test_overflow();
        clear_tabs();
        for (int t = 0; t < 100; t++) ready_tab[t] = 1'b0;
        for (int t = 10; t < 16; t++) flag_tab[t] = 1'b1;
        run_frame(-1, "overflow");
        checks++;
        if (o_kp_count !== 16'd4 || o_overflow !== 1'b1 || done_t !== 104) begin
            errors++;
            $display("FAIL overflow final: got cnt=%0d ovf=%b done_t=%0d want 4/1/104", o_kp_count, o_overflow, done_t);
        end
    endtask

    task automatic test_req_ignored();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            i_frame_req = 1'b1;
            i_det_ready = 1'b0;
            #1;
            checks++;
            if (o_mem_rd !== 1'b0 || o_busy !== 1'b0) begin
                errors++; $display("FAIL req_not_ready: got rd=%b busy=%b want 0/0", o_mem_rd, o_busy);
            end
        end
        @(negedge clk);
        i_frame_req = 1'b0;
        #1;
        checks++;
        if (o_det_start !== 1'b0 || o_busy !== 1'b0) begin
            errors++; $display("FAIL req_not_ready_after: got start=%b busy=%b want 0/0", o_det_start, o_busy);
        end
        clear_tabs();
        for (int t = 1; t < MAXC; t++) req_tab[t] = 1'($urandom_range(0, 1));
        run_frame(-1, "req_midstream");
    endtask

    task automatic test_push_pop_full();
        clear_tabs();
        for (int t = 0; t < 30; t++) ready_tab[t] = (t == 20);
        for (int t = 10; t < 14; t++) flag_tab[t] = 1'b1;
        flag_tab[20] = 1'b1;
        run_frame(-1, "push_pop_full");
        checks++;
        if (o_kp_count !== 16'd5 || o_overflow !== 1'b0) begin
            errors++; $display("FAIL push_pop_full final: got cnt=%0d ovf=%b want 5/0", o_kp_count, o_overflow);
        end
    endtask

    task automatic test_reset_mid_stream();
        clear_tabs();
        for (int t = 0; t < MAXC; t++) ready_tab[t] = 1'b0;
        for (int t = 5; t < 9; t++) flag_tab[t] = 1'b1;
        run_frame(20, "pre_reset");
        i_rst_n = 1'b0;
        #1;
        checks++;
        if ({o_busy, o_frame_done, o_mem_rd, o_mem_addr, o_det_start, o_det_pixel, o_kp_valid,
             o_kp_x, o_kp_y, o_kp_score, o_kp_count, o_overflow} !== '0) begin
            errors++;
            $display("FAIL reset_mid_stream: got busy=%b rd=%b addr=%0d pix=%0d valid=%b cnt=%0d ovf=%b want all 0",
                     o_busy, o_mem_rd, o_mem_addr, o_det_pixel, o_kp_valid, o_kp_count, o_overflow);
        end
        exp_q.delete();
        m_count = 0;
        m_ovf   = 0;
        i_det_flag = 1'b0;
        i_kp_ready = 1'b1;
        @(negedge clk);
        i_rst_n = 1'b1;
        clear_tabs();
        run_frame(-1, "after_reset");
    endtask

    task automatic test_random_frames();
        for (int f = 0; f < 3; f++) begin
            clear_tabs();
            for (int t = 0; t < MAXC; t++) begin
                flag_tab[t]  = ($urandom_range(0, 5) == 0);
                ready_tab[t] = 1'($urandom_range(0, 1));
            end
            run_frame(-1, "random");
        end
    endtask

    initial begin
        errors      = 0;
        checks      = 0;
        m_count     = 0;
        m_ovf       = 0;
        i_rst_n     = 1'b0;
        i_frame_req = 1'b0;
        i_det_ready = 1'b0;
        i_det_flag  = 1'b0;
        i_det_x     = '0;
        i_det_y     = '0;
        i_det_score = '0;
        i_det_end   = 1'b0;
        i_kp_ready  = 1'b1;
        test_reset();
        test_single_frame();
        test_two_keypoints();
        test_overflow();
        test_req_ignored();
        test_push_pop_full();
        test_reset_mid_stream();
        test_random_frames();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
